// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional stall counter output enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_skid #(
    parameter int CTRL_W = 26,
    parameter int DATA_W = 99
`ifdef PIPE_STALL_CNT_EN
    ,
    parameter int STALL_CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    state_t            state_nx;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              accept;
    logic              drain;
    logic              load_m_in;
    logic              load_m_s;
    logic              load_s_in;
    logic              clr_m;

    assign out_valid = (state != EMPTY);
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_nx  = state;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s_in = 1'b0;
        clr_m     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx  = ONE;
                    load_m_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    state_nx  = TWO;
                    load_s_in = 1'b1;
                end else if (drain) begin
                    state_nx = EMPTY;
                    clr_m    = 1'b1;
                end
            end
            TWO: begin
                if (drain) begin
                    state_nx = ONE;
                    load_m_s = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
        // Flush still completes the handshakes but stores nothing.
        if (flush) begin
            state_nx  = EMPTY;
            load_m_in = 1'b0;
            load_m_s  = 1'b0;
            load_s_in = 1'b0;
            clr_m     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx != TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_ctrl <= '0;
            m_data <= '0;
            s_ctrl <= '0;
            s_data <= '0;
        end else if (flush) begin
            m_ctrl <= '0;
            s_ctrl <= '0;
        end else begin
            if (load_m_in) begin
                m_ctrl <= in_ctrl;
                m_data <= in_data;
            end else if (load_m_s) begin
                m_ctrl <= s_ctrl;
                m_data <= s_data;
            end else if (clr_m) begin
                m_ctrl <= '0;
            end
            if (load_s_in) begin
                s_ctrl <= in_ctrl;
                s_data <= in_data;
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, stall counter sequence when
// PIPE_STALL_CNT_EN is defined, then random traffic against a queue reference model.
module tb_pipe_stage_skid;

    localparam int CW  = 26;
    localparam int DW  = 99;
    localparam int SCW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
    logic [SCW-1:0] stall_cnt;
`endif

    always #5 clk = ~clk;

`ifdef PIPE_STALL_CNT_EN
    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .STALL_CNT_W(SCW)) dut (
`else
    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
`endif
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;

    typedef struct {
        logic          rst, iv, fl, ordy;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic          ev, er;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: an ordered list of held instructions, at most two.
    item_t         q[$];
    logic          m_rdy  = 1'b1;
    logic [DW-1:0] m_last = '0;
    int unsigned   m_cnt  = 0;

    vec_t vt[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic fl, input logic ordy,
                        input logic [CW-1:0] c, input logic [DW-1:0] d);
        logic acc, drn;
        item_t it;
        rst = r; in_valid = iv; flush = fl; out_ready = ordy; in_ctrl = c; in_data = d;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            acc = iv && m_rdy;
            drn = (q.size() > 0) && ordy;
            if ((q.size() > 0) && !ordy && (m_cnt < (1 << SCW) - 1)) m_cnt++;
            if (fl) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) begin
                    it.c = c;
                    it.d = d;
                    q.push_back(it);
                end
            end
            if (q.size() > 0) m_last = q[0].d;
        end
        m_rdy = (q.size() < 2);
        @(negedge clk);
        check("model_out_valid", {127'b0, out_valid}, {127'b0, (q.size() > 0)});
        check("model_in_ready", {127'b0, in_ready}, {127'b0, m_rdy});
        check("model_out_ctrl", {102'b0, out_ctrl}, (q.size() > 0) ? {102'b0, q[0].c} : 128'b0);
        check("model_out_data", {29'b0, out_data}, {29'b0, m_last});
`ifdef PIPE_STALL_CNT_EN
        check("model_stall_cnt", {125'b0, stall_cnt}, 128'(m_cnt));
`endif
    endtask

    task automatic addv(input logic r, input logic iv, input logic fl, input logic ordy,
                        input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ev, input logic er, input logic [CW-1:0] ec,
                        input logic [DW-1:0] ed);
        vec_t v;
        v.rst = r; v.iv = iv; v.fl = fl; v.ordy = ordy; v.c = c; v.d = d;
        v.ev = ev; v.er = er; v.ec = ec; v.ed = ed;
        vt.push_back(v);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;

        //   rst   iv    fl    ordy  ctrl            data         ev    er    ectrl           edata
        addv(1'b1, 1'b1, 1'b0, 1'b0, 26'h3FFFFFF, 99'hFF,  1'b0, 1'b1, 26'h0, 99'h0);
        addv(1'b1, 1'b1, 1'b0, 1'b0, 26'h3FFFFFF, 99'hFF,  1'b0, 1'b1, 26'h0, 99'h0);
        addv(1'b0, 1'b1, 1'b0, 1'b1, 26'h1, 99'hA1,  1'b1, 1'b1, 26'h1, 99'hA1);
        addv(1'b0, 1'b1, 1'b0, 1'b1, 26'h2, 99'hA2,  1'b1, 1'b1, 26'h2, 99'hA2);
        addv(1'b0, 1'b1, 1'b0, 1'b1, 26'h3, 99'hA3,  1'b1, 1'b1, 26'h3, 99'hA3);
        addv(1'b0, 1'b0, 1'b0, 1'b1, 26'h0, 99'h0,   1'b0, 1'b1, 26'h0, 99'hA3);
        addv(1'b0, 1'b1, 1'b0, 1'b0, 26'h4, 99'hB4,  1'b1, 1'b1, 26'h4, 99'hB4);
        addv(1'b0, 1'b1, 1'b0, 1'b0, 26'h5, 99'hB5,  1'b1, 1'b0, 26'h4, 99'hB4);
        addv(1'b0, 1'b1, 1'b0, 1'b0, 26'h6, 99'hB6,  1'b1, 1'b0, 26'h4, 99'hB4);
        addv(1'b0, 1'b1, 1'b0, 1'b1, 26'h6, 99'hB6,  1'b1, 1'b1, 26'h5, 99'hB5);
        addv(1'b0, 1'b1, 1'b0, 1'b1, 26'h6, 99'hB6,  1'b1, 1'b1, 26'h6, 99'hB6);
        addv(1'b0, 1'b0, 1'b0, 1'b1, 26'h0, 99'h0,   1'b0, 1'b1, 26'h0, 99'hB6);
        addv(1'b0, 1'b1, 1'b0, 1'b0, 26'h7, 99'hC7,  1'b1, 1'b1, 26'h7, 99'hC7);
        addv(1'b0, 1'b1, 1'b0, 1'b0, 26'h8, 99'hC8,  1'b1, 1'b0, 26'h7, 99'hC7);
        addv(1'b0, 1'b1, 1'b1, 1'b0, 26'h9, 99'hC9,  1'b0, 1'b1, 26'h0, 99'hC7);
        addv(1'b0, 1'b0, 1'b0, 1'b1, 26'h0, 99'h0,   1'b0, 1'b1, 26'h0, 99'hC7);
        addv(1'b0, 1'b1, 1'b0, 1'b1, 26'hA, 99'hE0,  1'b1, 1'b1, 26'hA, 99'hE0);
        addv(1'b0, 1'b0, 1'b0, 1'b1, 26'h0, 99'h0,   1'b0, 1'b1, 26'h0, 99'hE0);
        addv(1'b0, 1'b1, 1'b0, 1'b0, 26'hB, 99'hF1,  1'b1, 1'b1, 26'hB, 99'hF1);
        addv(1'b0, 1'b1, 1'b1, 1'b1, 26'hC, 99'hF2,  1'b0, 1'b1, 26'h0, 99'hF1);
        addv(1'b0, 1'b1, 1'b0, 1'b0, 26'h11, 99'h111, 1'b1, 1'b1, 26'h11, 99'h111);
        addv(1'b0, 1'b1, 1'b0, 1'b0, 26'h12, 99'h112, 1'b1, 1'b0, 26'h11, 99'h111);
        addv(1'b1, 1'b1, 1'b1, 1'b1, 26'h13, 99'h113, 1'b0, 1'b1, 26'h0, 99'h0);

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].iv, vt[i].fl, vt[i].ordy, vt[i].c, vt[i].d);
            check($sformatf("vec%0d_out_valid", i), {127'b0, out_valid}, {127'b0, vt[i].ev});
            check($sformatf("vec%0d_in_ready", i), {127'b0, in_ready}, {127'b0, vt[i].er});
            check($sformatf("vec%0d_out_ctrl", i), {102'b0, out_ctrl}, {102'b0, vt[i].ec});
            check($sformatf("vec%0d_out_data", i), {29'b0, out_data}, {29'b0, vt[i].ed});
        end

`ifdef PIPE_STALL_CNT_EN
        step(1'b0, 1'b1, 1'b0, 1'b0, 26'h21, 99'h21);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        check("stall_cnt_5", {125'b0, stall_cnt}, 128'd5);
        step(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        check("stall_cnt_after_flush", {125'b0, stall_cnt}, 128'd5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 26'h22, 99'h22);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        check("stall_cnt_sat", {125'b0, stall_cnt}, 128'd7);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        check("stall_cnt_rst", {125'b0, stall_cnt}, 128'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 6),
                 CW'($urandom), {3'($urandom), $urandom, $urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generalised pipeline stage register for the 16-bit pipelined processor, replacing fixed per-field dff banks between stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one parametrised control vector and one data vector per instruction.
- Adds a valid/ready handshake with a 2-entry skid buffer, so in_ready is a registered output and the hazard unit can stall without a combinational ready path.
- Adds a synchronous flush that turns all held instructions into bubbles with zeroed control.

Parameters:
- CTRL_W, 26, width of the control vector (RegWrite, MemWrite, Halt, aluops, ...); these bits are zeroed in every bubble.
- DATA_W, 99, width of the data vector (PC, instruction, operands, extension, write address); this vector is not cleared on bubbles.
- STALL_CNT_W, 16, width of the optional stall counter. Used only when PIPE_STALL_CNT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle; driven directly from a register.
- in_ctrl  in  CTRL_W  incoming control vector.
- in_data  in  DATA_W  incoming data vector.
- flush  in  1  squash all held instructions (branch/jump redirect).
- out_valid  out  1  out_ctrl/out_data hold a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  outgoing control vector; all zeros whenever out_valid=0.
- out_data  out  DATA_W  outgoing data vector.
- stall_cnt  out  STALL_CNT_W  present only when PIPE_STALL_CNT_EN is defined.

Behaviour:
- Storage: main register M (drives the outputs) and skid register S. Each has its own valid, ctrl and data.
- Handshake events:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- States:
  - EMPTY: M and S both invalid.
  - ONE: M valid, S invalid.
  - TWO: M and S both valid.
- in_ready = 1 in EMPTY and ONE, 0 in TWO. It is registered, with no combinational path from out_ready.
- Transitions (priority: rst > flush > handshake):
  - EMPTY: accept -> ONE, M<=in. Otherwise stay EMPTY.
  - ONE: accept & drain -> ONE, M<=in. accept & ~drain -> TWO, S<=in. ~accept & drain -> EMPTY. Otherwise hold.
  - TWO: drain -> ONE, M<=S. Otherwise hold; in_valid is ignored because in_ready=0.
- Latency and throughput:
  - 1 cycle in_valid->out_valid from EMPTY or with continuous drain.
  - Sustained 1 instruction/cycle when out_ready=1.
- Ordering: strict FIFO; S always contains the younger instruction.
- Hold: while not draining, out_ctrl/out_data are stable and out_valid stays 1. Downstream may deassert out_ready indefinitely.
- Bubble rule: whenever M goes invalid (drain to EMPTY, flush, rst), M.ctrl<=0. out_data holds its last value when invalid except after rst.
- flush=1:
  - Next state is EMPTY; M.ctrl and S.ctrl <=0.
  - An accept or drain in the same cycle still completes as a handshake, but the accepted instruction is discarded.
  - in_ready=1 on the cycle after flush.
- rst=1 (synchronous, any state, mid-transfer included):
  - Next cycle: out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
  - S is cleared to all zeros.
  - rst overrides flush and both handshakes.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0.
- Width rule: ctrl and data are bit-exact copies; no sign or zero extension inside the block.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - Adds the stall_cnt output and a STALL_CNT_W-bit counter.
  - Counter increments on every cycle with out_valid=1 & out_ready=0.
  - Saturates at all-ones with no wrap.
  - Cleared only by rst; flush does not clear it.
  - Updates one cycle after the stalled cycle.
- Undefined: no stall_cnt port, no counter logic; everything else is identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1, in_ctrl=0x3FFFFFF -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1 after the first edge.
- Streaming: out_ready=1, send A,B,C (ctrl 0x1,0x2,0x3) on back-to-back cycles -> each appears on out_ctrl exactly 1 cycle later, in order, no gaps, in_ready stays 1.
- Backpressure:
  - Send A,B,C with out_ready=0 -> A held on outputs, B in S, in_ready=0 from the cycle after B is accepted, C held upstream.
  - Raise out_ready -> A, B, C emerge in order.
- Flush: enter state TWO, assert flush with in_valid=1 (D) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; D is never output.
- Drain to empty: single instruction E with out_ready=1 -> out_valid=1 for one cycle, then out_valid=0 and out_ctrl=0 while out_data still equals E's data.
- PIPE_STALL_CNT_EN defined:
  - Hold a valid output with out_ready=0 for 5 cycles -> stall_cnt=5.
  - With STALL_CNT_W=3, stall for 10 cycles -> stall_cnt saturates at 7.
  - flush leaves the value unchanged.
